// File: rtl/inst_sram_bridge.sv
// Instruction-side SRAM-like slave: accepts word fetches, reads a 1-cycle synchronous RAM,
// and returns words in order after a fixed LATENCY; cancel flushes everything in flight.
module inst_sram_bridge #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        cancel,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [LATENCY:1] v_q;
    logic [31:0]      d_q [2:LATENCY];
    logic [CW-1:0]    out_q;

    logic accept;
    logic deliver;
    logic slot_free;
    logic unused_addr_bits;

    // Byte offset is dropped on the RAM side; fetch owns alignment faults.
    assign unused_addr_bits = ^inst_addr[1:0];

    // Handshake, RAM drive and response outputs.
    always_comb begin
        slot_free    = 1'b0;
        inst_addr_ok = 1'b0;
        accept       = 1'b0;
        deliver      = 1'b0;
        ram_en       = 1'b0;
        ram_addr     = {inst_addr[31:2], 2'b00};
        inst_data_ok = 1'b0;
        inst_rdata   = d_q[LATENCY];
        busy         = 1'b0;

        // A word leaving this cycle frees its slot for a same-cycle accept.
        slot_free    = (out_q < CW'(MAX_OUT)) || v_q[LATENCY];
        inst_addr_ok = !reset && !cancel && slot_free;
        accept       = inst_req && inst_addr_ok;
        deliver      = v_q[LATENCY] && !cancel && !reset;
        ram_en       = accept;
        inst_data_ok = deliver;
        busy         = (out_q != '0);
    end

    // Valid pipeline and outstanding counter.
    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            v_q   <= '0;
            out_q <= '0;
        end else begin
            v_q <= {v_q[LATENCY-1:1], accept};
            if (accept && !deliver) begin
                out_q <= out_q + CW'(1);
            end else if (!accept && deliver) begin
                out_q <= out_q - CW'(1);
            end
        end
    end

    // Data pipeline: each stage loads only when its valid moves in, so rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 2; k <= LATENCY; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            if (v_q[1]) begin
                d_q[2] <= ram_rdata;
            end
            for (int k = 3; k <= LATENCY; k++) begin
                if (v_q[k-1]) begin
                    d_q[k] <= d_q[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Scoreboard bench for inst_sram_bridge: three instances (L2/M2, L3/M3, L3/M1) share one clock.
module tb_inst_sram_bridge;

    typedef struct packed {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic clk;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;
    bit run = 0;

    logic [2:0]       req;
    logic [2:0][31:0] addr;
    logic [2:0]       cancel_s;
    logic [2:0]       rst_s;
    logic [2:0]       addr_ok;
    logic [2:0][31:0] rdata;
    logic [2:0]       data_ok;
    logic [2:0]       ram_en;
    logic [2:0][31:0] ram_addr;
    logic [2:0][31:0] ram_rdata;
    logic [2:0]       busy;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned LAT = (g == 0) ? 2 : 3;
        localparam int unsigned MO  = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
        inst_sram_bridge #(.LATENCY(LAT), .MAX_OUT(MO)) u_dut (
            .clk          (clk),
            .reset        (rst_s[g]),
            .inst_req     (req[g]),
            .inst_addr    (addr[g]),
            .inst_addr_ok (addr_ok[g]),
            .inst_rdata   (rdata[g]),
            .inst_data_ok (data_ok[g]),
            .cancel       (cancel_s[g]),
            .ram_en       (ram_en[g]),
            .ram_addr     (ram_addr[g]),
            .ram_rdata    (ram_rdata[g]),
            .busy         (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: word = C0DE in the top half, address low half below.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ram_en[i] === 1'b1) ram_rdata[i] <= {16'hC0DE, ram_addr[i][15:0]};
        end
    end

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, i, cyc, act, exp);
        end
    endtask

    // One cycle on instance i; exp_ok/exp_busy value 2 means not checked.
    task automatic step(input int i, input logic r, input logic [31:0] a, input logic c,
                        input logic rs, input int exp_ok, input logic [31:0] exp_data,
                        input int exp_busy);
        @(posedge clk);
        #1;
        req         = '0;
        cancel_s    = '0;
        req[i]      = r;
        addr[i]     = a;
        cancel_s[i] = c;
        rst_s[i]    = rs;
        if (c || rs) qclear(i);
        @(negedge clk);
        if (exp_ok != 2) chk("addr_ok", i, 32'(addr_ok[i]), 32'(exp_ok));
        if (exp_ok != 2 || !r) chk("ram_en", i, 32'(ram_en[i]), 32'(r && exp_ok == 1));
        if (exp_busy != 2) chk("busy", i, 32'(busy[i]), 32'(exp_busy));
        if (r && exp_ok == 1) begin
            chk("ram_addr", i, ram_addr[i], {a[31:2], 2'b00});
            qpush(i, '{data: exp_data, due: cyc + lat_of(i)});
        end
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) step(i, 1'b0, 32'h0, 1'b0, 1'b0, 2, 32'h0, 2);
    endtask

    // Response monitor: every pulse must match the queue head in data and cycle.
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 3; i++) begin
                if (data_ok[i] === 1'b1) begin
                    checks++;
                    if (qsize(i) == 0) begin
                        failures++;
                        $display("FAIL unexpected_data_ok inst=%0d cyc=%0d rdata=%h required=no_pulse",
                                 i, cyc, rdata[i]);
                    end else begin
                        exp_t e;
                        e = qfront(i);
                        qpop(i);
                        if (rdata[i] !== e.data || cyc != e.due) begin
                            failures++;
                            $display("FAIL data_ok inst=%0d actual=%h@%0d required=%h@%0d",
                                     i, rdata[i], cyc, e.data, e.due);
                        end
                    end
                end else if (qsize(i) != 0 && qfront(i).due <= cyc) begin
                    exp_t e;
                    e = qfront(i);
                    qpop(i);
                    checks++;
                    failures++;
                    $display("FAIL missing_data_ok inst=%0d cyc=%0d actual=none required=%h@%0d",
                             i, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        req       = '0;
        addr      = '0;
        cancel_s  = '0;
        rst_s     = '1;
        ram_rdata = '0;
        repeat (2) @(posedge clk);

        // Requests during reset are blocked.
        for (int i = 0; i < 3; i++) step(i, 1'b1, 32'h10, 1'b0, 1'b1, 0, 32'h0, 2);
        @(posedge clk);
        #1;
        req   = '0;
        rst_s = '0;
        @(negedge clk);
        run = 1;
        for (int i = 0; i < 3; i++) begin
            chk("post_reset_addr_ok", i, 32'(addr_ok[i]), 32'h1);
            chk("post_reset_data_ok", i, 32'(data_ok[i]), 32'h0);
            chk("post_reset_rdata", i, rdata[i], 32'h0);
            chk("post_reset_busy", i, 32'(busy[i]), 32'h0);
        end

        // Single fetch, LATENCY=2.
        step(0, 1'b1, 32'h34, 1'b0, 1'b0, 1, 32'hC0DE0034, 0);
        step(0, 1'b0, 32'h0, 1'b0, 1'b0, 2, 32'h0, 1);
        step(0, 1'b0, 32'h0, 1'b0, 1'b0, 2, 32'h0, 1);
        step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1, 32'h0, 0);

        // Streaming, LATENCY=MAX_OUT=3.
        step(1, 1'b1, 32'h34, 1'b0, 1'b0, 1, 32'hC0DE0034, 2);
        step(1, 1'b1, 32'h38, 1'b0, 1'b0, 1, 32'hC0DE0038, 2);
        step(1, 1'b1, 32'h3C, 1'b0, 1'b0, 1, 32'hC0DE003C, 2);
        step(1, 1'b1, 32'h40, 1'b0, 1'b0, 1, 32'hC0DE0040, 2);
        step(1, 1'b1, 32'h44, 1'b0, 1'b0, 1, 32'hC0DE0044, 2);
        step(1, 1'b1, 32'h48, 1'b0, 1'b0, 1, 32'hC0DE0048, 2);
        idle(1, 4);

        // Throttle, LATENCY=3 MAX_OUT=1, request held high.
        step(2, 1'b1, 32'h100, 1'b0, 1'b0, 1, 32'hC0DE0100, 2);
        step(2, 1'b1, 32'h104, 1'b0, 1'b0, 0, 32'h0, 1);
        step(2, 1'b1, 32'h104, 1'b0, 1'b0, 0, 32'h0, 1);
        step(2, 1'b1, 32'h104, 1'b0, 1'b0, 1, 32'hC0DE0104, 1);
        step(2, 1'b1, 32'h108, 1'b0, 1'b0, 0, 32'h0, 1);
        step(2, 1'b1, 32'h108, 1'b0, 1'b0, 0, 32'h0, 1);
        step(2, 1'b1, 32'h108, 1'b0, 1'b0, 1, 32'hC0DE0108, 1);
        idle(2, 4);

        // Cancel the cycle before the first response, then refetch.
        step(1, 1'b1, 32'h200, 1'b0, 1'b0, 1, 32'hC0DE0200, 2);
        step(1, 1'b1, 32'h204, 1'b0, 1'b0, 1, 32'hC0DE0204, 2);
        step(1, 1'b1, 32'h300, 1'b1, 1'b0, 0, 32'h0, 2);
        step(1, 1'b1, 32'h380, 1'b0, 1'b0, 1, 32'hC0DE0380, 0);
        idle(1, 4);

        // Cancel exactly on the due cycle suppresses that response.
        step(1, 1'b1, 32'h240, 1'b0, 1'b0, 1, 32'hC0DE0240, 0);
        idle(1, 2);
        step(1, 1'b0, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1);
        step(1, 1'b0, 32'h0, 1'b0, 1'b0, 1, 32'h0, 0);
        idle(1, 2);

        // Misaligned address is word-aligned on the RAM side.
        step(0, 1'b1, 32'h36, 1'b0, 1'b0, 1, 32'hC0DE0034, 0);
        idle(0, 3);

        // Reset with two in flight.
        step(1, 1'b1, 32'h400, 1'b0, 1'b0, 1, 32'hC0DE0400, 0);
        step(1, 1'b1, 32'h404, 1'b0, 1'b0, 1, 32'hC0DE0404, 1);
        step(1, 1'b0, 32'h0, 1'b0, 1'b1, 0, 32'h0, 2);
        step(1, 1'b0, 32'h0, 1'b0, 1'b0, 1, 32'h0, 0);
        idle(1, 5);

        for (int i = 0; i < 3; i++) chk("drained_queue", i, 32'(qsize(i)), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
